// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Holds the FSM state encoding and counter width helper.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam int MAX_NUM_REQ = 8;

  // Width needed to hold 0..n-1, never below 1.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set req bit at or after rr_ptr.
// Ports: req, rr_ptr in; one-hot pick and valid out.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [N-1:0] rot;
  logic [N-1:0] oh;

  always_comb begin
    // rot[i] is req[(i + rr_ptr) mod N]
    rot = N'({req, req} >> rr_ptr);
    oh  = '0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && (oh == '0)) oh[i] = 1'b1;
    end
    // rotate the winner back left by rr_ptr
    pick = N'({oh, oh} >> (N - int'(rr_ptr)));
  end

  assign valid = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among producers.
// Ports: req/req_data from producers, fifo_full in; grant, ack, fifo_wr_en/data, busy out.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      fifo_full,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      busy
);

  localparam int PW = idx_w(NUM_REQ);
  localparam int CW = idx_w(MAX_BURST);

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [NUM_REQ-1:0] pick;
  logic               pick_vld;
  logic [PW-1:0]      rr_ptr, ptr_n, nxt_ptr;
  logic [CW-1:0]      cnt, cnt_n;
  logic               owner_req;
  logic               last_word;

  rr_priority_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .valid  (pick_vld)
  );

  assign ack        = grant & req & {NUM_REQ{~fifo_full}};
  assign fifo_wr_en = |ack;
  assign busy       = (state == ST_OWN);
  assign owner_req  = |(grant & req);
  assign last_word  = fifo_wr_en && (cnt == CW'(MAX_BURST - 1));

  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) fifo_wr_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // pointer to the producer after the current owner
  always_comb begin
    nxt_ptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) nxt_ptr = PW'((i + 1) % NUM_REQ);
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    cnt_n   = cnt;
    ptr_n   = rr_ptr;
    unique case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_n = pick;
          cnt_n   = '0;
          state_n = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!owner_req || last_word) begin
          grant_n = '0;
          ptr_n   = nxt_ptr;
          state_n = ST_IDLE;
        end else if (fifo_wr_en) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        grant_n = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      grant  <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      cnt    <= cnt_n;
      rr_ptr <= ptr_n;
    end
  end

endmodule
